// File: rtl/if_stage.sv
// Instruction-fetch stage: architectural PC, byte-loadable instruction memory,
// next-PC selection and a RUN/HALT state that stops fetch on bad addresses.
module if_stage #(
  parameter int          IMEM_BYTES = 256,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        load_we,
  input  logic [63:0] load_addr,
  input  logic [7:0]  load_data,
  output logic [63:0] PC_out,
  output logic [31:0] Instruction,
  output logic        fetch_valid,
  output logic        halted,
  output logic        misaligned
);

  localparam int          AW      = $clog2(IMEM_BYTES);
  localparam logic [63:0] MEM_SZ  = 64'(IMEM_BYTES);
  localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES - 4);

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_pc;
  logic [63:0] w_pc_nxt;
  logic        r_mis;
  logic        w_mis_nxt;
  logic        w_in_range;
  logic        w_br_bad;

  logic [7:0]        r_mem [IMEM_BYTES];
  logic [3:0][63:0]  w_addr;
  logic [3:0][7:0]   w_byte;

  // Program load is independent of reset so a loader can run while held
  always_ff @(posedge clk) begin
    if (load_we && (load_addr < MEM_SZ))
      r_mem[load_addr[AW-1:0]] <= load_data;
  end

  always_comb begin
    w_addr = '0;
    w_byte = '0;
    for (int k = 0; k < 4; k++) begin
      w_addr[k] = r_pc + 64'(k);
      if (w_addr[k] < MEM_SZ)
        w_byte[k] = r_mem[w_addr[k][AW-1:0]];
    end
  end

  assign w_in_range = (r_pc <= LAST_PC);
  assign w_br_bad   = branch_taken && (branch_target[1:0] != 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_mis_nxt   = r_mis;
    if (r_state == S_RUN) begin
      if (!w_in_range) begin
        w_state_nxt = S_HALT;
      end else if (w_br_bad) begin
        w_state_nxt = S_HALT;
        w_mis_nxt   = 1'b1;
      end else if (branch_taken) begin
        w_pc_nxt = branch_target;
      end else if (!stall) begin
        w_pc_nxt = r_pc + 64'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_mis   <= w_mis_nxt;
    end
  end

  assign PC_out      = r_pc;
  assign Instruction = {w_byte[3], w_byte[2], w_byte[1], w_byte[0]};
  assign halted      = (r_state == S_HALT);
  assign fetch_valid = (r_state == S_RUN) && w_in_range;
  assign misaligned  = r_mis;

endmodule
